// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus slice seen by the memory-mapped UART transmitter.
// The CPU/top level drives the MEM-stage address and store data; the UART returns select and read data.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        we;
    logic        sel;
    logic [31:0] rd_data;

    modport master (
        output addr,
        output wr_data,
        output we,
        input  sel,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  we,
        output sel,
        output rd_data
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: store-fed TX FIFO serialized 8N1, LSB first.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module mmio_uart_tx #(
    parameter int          CLK_HZ     = 100000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIV - 1);
    localparam logic [4:0]       DEPTH_CNT = 5'(FIFO_DEPTH);

`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       count;
    logic             overflow;
    logic             full;
    logic             empty;
    logic [7:0]       head;

    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             clr_ovf;
    logic             pop;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             txd_next;
    logic             busy_next;
    logic             bit_end;
`ifdef MMIO_UART_PARITY_EN
    logic             par, par_next;
`endif

    logic             unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wr_data[31:8]};

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == 5'd0);
    assign head  = mem[rd_ptr];

    assign bus.sel     = (bus.addr[31:3] == BASE_ADDR[31:3]);
    assign bus.rd_data = (bus.sel && bus.addr[2])
                         ? {23'd0, count, overflow, busy, empty, full}
                         : 32'd0;

    // A push into a full FIFO still lands when the FSM pops the head that same cycle.
    assign push_req = bus.we && bus.sel && !bus.addr[2];
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign clr_ovf  = bus.we && bus.sel && bus.addr[2] && bus.wr_data[3];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.wr_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 5'd1;
            end else if (!push_ok && pop) begin
                count <= count - 5'd1;
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            txd      <= 1'b1;
            busy     <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= cnt_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            txd      <= txd_next;
            busy     <= busy_next;
`ifdef MMIO_UART_PARITY_EN
            par      <= par_next;
`endif
        end
    end

    assign bit_end = (baud_cnt == LAST_CNT);

    // txd is registered, so each transition loads the level of the state being entered.
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        txd_next   = txd;
        busy_next  = busy;
        pop        = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        par_next   = par;
`endif
        case (state)
            S_IDLE: begin
                cnt_next  = '0;
                txd_next  = 1'b1;
                busy_next = 1'b0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
`ifdef MMIO_UART_PARITY_EN
                    par_next   = ^head;
`endif
                    state_next = S_START;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                    bit_next   = 3'd0;
                    txd_next   = shift[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_next = S_PARITY;
                        txd_next   = par;
`else
                        state_next = S_STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        txd_next = shift[1];
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    cnt_next   = '0;
                    txd_next   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
`ifdef MMIO_UART_PARITY_EN
                        par_next   = ^head;
`endif
                        state_next = S_START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        txd_next   = 1'b1;
                        busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with DIV=16, 16-entry FIFO at 0x1000.
// Frame timing and bit checks follow MMIO_UART_PARITY_EN when it is defined.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int DIV       = 16;
    localparam int FRAME_CYC = NBITS * DIV;
    localparam logic [31:0] TXDATA = 32'h0000_1000;
    localparam logic [31:0] STATUS = 32'h0000_1004;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (16),
        .BASE_ADDR  (32'h0000_1000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .txd  (txd),
        .busy (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store: inputs settle after an edge, get captured at the next edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.we      = 1'b1;
        @(posedge clk);
        #1;
        bus.we      = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        v = bus.rd_data;
    endtask

    function automatic logic expectedBit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef MMIO_UART_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called just after the edge where the start bit began; returns one frame later.
    task automatic checkFrame(input logic [7:0] b);
        for (int i = 0; i < NBITS; i++) begin
            repeat (8) tick();
            checkOutput($sformatf("frame_%02h_bit%0d", b, i), {31'd0, txd}, {31'd0, expectedBit(b, i)});
            checkOutput($sformatf("frame_%02h_busy%0d", b, i), {31'd0, busy}, 32'd1);
            repeat (8) tick();
        end
    endtask

    logic [31:0] v;
    logic        saw_activity;

    initial begin
        rst         = 1'b1;
        bus.addr    = 32'd0;
        bus.wr_data = 32'd0;
        bus.we      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        readReg(STATUS, v);
        checkOutput("reset_sel", {31'd0, bus.sel}, 32'd1);
        checkOutput("reset_status", v, 32'h2);
        checkOutput("reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        readReg(TXDATA, v);
        checkOutput("txdata_read", v, 32'h0);

        applyStimulus(TXDATA, 32'h0000_0055);
        readReg(STATUS, v);
        checkOutput("status_after_push", v, 32'h10);
        tick();
        checkOutput("start_txd", {31'd0, txd}, 32'd0);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        readReg(STATUS, v);
        checkOutput("status_sending", v, 32'h6);
        checkFrame(8'h55);
        checkOutput("end_busy", {31'd0, busy}, 32'd0);
        checkOutput("end_txd", {31'd0, txd}, 32'd1);
        readReg(STATUS, v);
        checkOutput("end_status", v, 32'h2);

        bus.addr = 32'h0000_1008;
        #1;
        checkOutput("sel_above", {31'd0, bus.sel}, 32'd0);
        checkOutput("rd_above", bus.rd_data, 32'd0);
        bus.addr = 32'h0000_0FFC;
        #1;
        checkOutput("sel_below", {31'd0, bus.sel}, 32'd0);
        checkOutput("rd_below", bus.rd_data, 32'd0);
        applyStimulus(32'h0000_1008, 32'h0000_00AA);
        applyStimulus(32'h0000_0FFC, 32'h0000_00AA);
        repeat (3) tick();
        checkOutput("outside_txd", {31'd0, txd}, 32'd1);
        checkOutput("outside_busy", {31'd0, busy}, 32'd0);
        readReg(STATUS, v);
        checkOutput("outside_status", v, 32'h2);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(TXDATA, i);
        end
        readReg(STATUS, v);
        checkOutput("overflow_status", v, 32'h10D);
        applyStimulus(STATUS, 32'h0000_0008);
        readReg(STATUS, v);
        checkOutput("overflow_cleared", v, 32'h105);

        repeat (FRAME_CYC - 17) tick();
        checkOutput("b2b_txd_1", {31'd0, txd}, 32'd0);
        checkOutput("b2b_busy_1", {31'd0, busy}, 32'd1);
        checkFrame(8'h01);
        checkOutput("b2b_txd_2", {31'd0, txd}, 32'd0);
        checkOutput("b2b_busy_2", {31'd0, busy}, 32'd1);

        repeat (40) tick();
        rst = 1'b1;
        #1;
        checkOutput("midreset_txd", {31'd0, txd}, 32'd1);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        #1;
        rst = 1'b0;
        readReg(STATUS, v);
        checkOutput("midreset_status", v, 32'h2);
        saw_activity = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) saw_activity = 1'b1;
        end
        checkOutput("midreset_quiet", {31'd0, saw_activity}, 32'd0);

`ifdef MMIO_UART_PARITY_EN
        applyStimulus(TXDATA, 32'h0000_0007);
        tick();
        checkOutput("parity_start", {31'd0, txd}, 32'd0);
        checkFrame(8'h07);
        checkOutput("parity_end_busy", {31'd0, busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
